// File: rtl/router_pkg.sv
// router_pkg
// Shared types and constants for the 1x3 router control path.
//   state_t      : sequencing FSM state encoding (fixed, 3 bits)
//   ADDR_INVALID : header address value that does not map to any FIFO
package router_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    WAIT_TILL_EMPTY    = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    LOAD_PARITY        = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

endpackage

// File: rtl/router_fsm_if.sv
// router_fsm_if
// Bundles the handshake and strobe signals between the router FSM and its
// surroundings (source, register block, output FIFOs).
//   Source side   : pkt_valid, data_in[1:0], busy
//   FIFO side     : fifo_full, fifo_empty_0..2, soft_reset_0..2, write_enb_reg
//   Register side : parity_done, low_pkt_valid, detect_add, lfd_state,
//                   ld_state, laf_state, full_state, rst_int_reg
// Modports:
//   master : the FSM (reads status, drives strobes)
//   slave  : the environment (drives status, reads strobes)
interface router_fsm_if;

  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0;
  logic       fifo_empty_1;
  logic       fifo_empty_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;

  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic       write_enb_reg;
  logic       busy;

  modport master (
    input  pkt_valid, data_in, fifo_full,
    input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2,
    input  parity_done, low_pkt_valid,
    output detect_add, lfd_state, ld_state, laf_state, full_state,
    output rst_int_reg, write_enb_reg, busy
  );

  modport slave (
    output pkt_valid, data_in, fifo_full,
    output fifo_empty_0, fifo_empty_1, fifo_empty_2,
    output soft_reset_0, soft_reset_1, soft_reset_2,
    output parity_done, low_pkt_valid,
    input  detect_add, lfd_state, ld_state, laf_state, full_state,
    input  rst_int_reg, write_enb_reg, busy
  );

endinterface

// File: rtl/router_fsm.sv
// router_fsm
// Packet-sequencing controller for the 1x3 router. Decodes the header
// address, waits for the addressed FIFO to drain, then walks the register
// block through first-data, payload, full-stall and parity phases.
// Ports:
//   clock  : rising-edge clock
//   resetn : synchronous, active-low reset
//   bus    : router_fsm_if.master (status in, phase strobes/handshakes out)
// All outputs are a Moore decode of state_q; nothing combinational from
// inputs reaches an output.
module router_fsm
  import router_pkg::*;
(
  input  logic         clock,
  input  logic         resetn,
  router_fsm_if.master bus
);

  state_t     state_q, state_d;
  logic [1:0] addr_q, addr_d;

  logic [1:0] addr_sel;
  logic       empty_sel;
  logic       soft_sel;
  logic       hdr_ok;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // While decoding, the header on data_in is the address of interest; once
  // past the header, the latched copy is used.
  always_comb begin
    addr_sel = (state_q == DECODE_ADDRESS) ? bus.data_in : addr_q;

    empty_sel = 1'b0;
    case (addr_sel)
      2'd0:    empty_sel = bus.fifo_empty_0;
      2'd1:    empty_sel = bus.fifo_empty_1;
      2'd2:    empty_sel = bus.fifo_empty_2;
      default: empty_sel = 1'b0;
    endcase

    // Only the FIFO owning the current packet may abort it.
    soft_sel = 1'b0;
    case (addr_q)
      2'd0:    soft_sel = bus.soft_reset_0;
      2'd1:    soft_sel = bus.soft_reset_1;
      2'd2:    soft_sel = bus.soft_reset_2;
      default: soft_sel = 1'b0;
    endcase

    hdr_ok = bus.pkt_valid && (bus.data_in != ADDR_INVALID);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;

    case (state_q)
      DECODE_ADDRESS: begin
        if (hdr_ok) begin
          addr_d  = bus.data_in;
          state_d = empty_sel ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (empty_sel) state_d = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA: begin
        state_d = LOAD_DATA;
      end
      LOAD_DATA: begin
        // Full takes priority so the parity byte is not written into a full FIFO.
        if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!bus.pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (bus.parity_done)        state_d = DECODE_ADDRESS;
        else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
        else                        state_d = LOAD_DATA;
      end
      LOAD_PARITY: begin
        state_d = CHECK_PARITY_ERROR;
      end
      CHECK_PARITY_ERROR: begin
        state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      default: begin
        state_d = DECODE_ADDRESS;
      end
    endcase

    if (soft_sel && (state_q != DECODE_ADDRESS)) state_d = DECODE_ADDRESS;
  end

  always_comb begin
    bus.detect_add    = 1'b0;
    bus.lfd_state     = 1'b0;
    bus.ld_state      = 1'b0;
    bus.laf_state     = 1'b0;
    bus.full_state    = 1'b0;
    bus.rst_int_reg   = 1'b0;
    bus.write_enb_reg = 1'b0;
    bus.busy          = 1'b0;

    case (state_q)
      DECODE_ADDRESS: begin
        bus.detect_add = 1'b1;
      end
      LOAD_FIRST_DATA: begin
        bus.lfd_state = 1'b1;
        bus.busy      = 1'b1;
      end
      LOAD_DATA: begin
        bus.ld_state      = 1'b1;
        bus.write_enb_reg = 1'b1;
      end
      WAIT_TILL_EMPTY: begin
        bus.busy = 1'b1;
      end
      FIFO_FULL_STATE: begin
        bus.full_state = 1'b1;
        bus.busy       = 1'b1;
      end
      LOAD_AFTER_FULL: begin
        bus.laf_state     = 1'b1;
        bus.write_enb_reg = 1'b1;
        bus.busy          = 1'b1;
      end
      LOAD_PARITY: begin
        bus.write_enb_reg = 1'b1;
        bus.busy          = 1'b1;
      end
      CHECK_PARITY_ERROR: begin
        bus.rst_int_reg = 1'b1;
        bus.busy        = 1'b1;
      end
      default: begin
        bus.detect_add = 1'b0;
      end
    endcase
  end

endmodule
